// File: rtl/led_pattern_sequencer_if.sv
// Avalon-MM register port of the LED pattern sequencer: a 2-bit address,
// a chipselect-qualified active-low write strobe, and a combinational read path.
interface led_pattern_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/led_pattern_sequencer.sv
// Autonomous LED pattern sequencer: static, rotate-left, rotate-right and blink, stepped by a prescaler.
// Define LED_SEQ_PWM_EN to add the CTRL[15:8] DUTY field and PWM gating of out_port.
module led_pattern_sequencer #(
  parameter int WIDTH      = 10,
  parameter int PRESCALE_W = 24
) (
  input  logic                          clk,
  input  logic                          reset_n,
  led_pattern_sequencer_if.slave        bus,
  output logic [WIDTH-1:0]              out_port,
  output logic                          irq
);
  typedef enum logic [1:0] {MODE_STATIC = 2'b00, MODE_ROL = 2'b01,
                            MODE_ROR = 2'b10, MODE_BLINK = 2'b11} mode_e;
  typedef enum logic {ST_IDLE, ST_RUN} state_e;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic                  en_q, en_d, irq_en_q, irq_en_d;
  logic [WIDTH-1:0]      pattern_q, pattern_d, work_q, work_d, base_q, base_d;
  logic [PRESCALE_W-1:0] period_q, period_d, presc_q, presc_d;
  logic [CNT_W-1:0]      step_cnt_q, step_cnt_d, wrap_lim;
  logic                  phase_q, phase_d, wrap_pending_q, wrap_pending_d, irq_q, irq_d;
  logic                  wr_en, run_cond, wrap;
  logic [7:0]            duty_rd;
  logic [WIDTH+7:0]      status_word;
  logic                  unused_wdata;

  assign unused_wdata = ^bus.writedata;
  assign wr_en        = bus.chipselect && !bus.write_n;
  assign run_cond     = en_q && (mode_q != MODE_STATIC);
  assign wrap_lim     = (mode_q == MODE_BLINK) ? CNT_W'(2) : CNT_W'(WIDTH);

  // NOTE: every variable gets a default before any branch, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    en_d           = en_q;
    irq_en_d       = irq_en_q;
    pattern_d      = pattern_q;
    period_d       = period_q;
    work_d         = work_q;
    presc_d        = presc_q;
    step_cnt_d     = step_cnt_q;
    phase_d        = phase_q;
    wrap_pending_d = wrap_pending_q;
    wrap           = 1'b0;

    unique case (state_q)
      ST_IDLE: if (run_cond)  state_d = ST_RUN;
      ST_RUN:  if (!run_cond) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // The countdown starts on the first cycle the run condition holds, so the
    // first step lands PERIOD+1 cycles after EN is sampled.
    if (!run_cond) begin
      work_d     = pattern_q;
      presc_d    = period_q;
      step_cnt_d = '0;
      phase_d    = 1'b1;
    end else if (presc_q == '0) begin
      presc_d = period_q;
      unique case (mode_q)
        MODE_ROL:   work_d  = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        MODE_ROR:   work_d  = {work_q[0], work_q[WIDTH-1:1]};
        MODE_BLINK: phase_d = !phase_q;
        default:    ;
      endcase
      if (step_cnt_q + CNT_W'(1) == wrap_lim) begin
        step_cnt_d = '0;
        wrap       = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + CNT_W'(1);
      end
    end else begin
      presc_d = presc_q - PRESCALE_W'(1);
    end

    if (wr_en) begin
      unique case (bus.address)
        2'd0: begin
          en_d     = bus.writedata[0];
          mode_d   = mode_e'(bus.writedata[2:1]);
          irq_en_d = bus.writedata[3];
          if (state_q == ST_RUN && mode_e'(bus.writedata[2:1]) != mode_q) begin
            step_cnt_d = '0;
            presc_d    = period_q;
          end
        end
        2'd1: begin
          pattern_d  = bus.writedata[WIDTH-1:0];
          work_d     = bus.writedata[WIDTH-1:0];
          step_cnt_d = '0;
          presc_d    = period_q;
        end
        2'd2: period_d = bus.writedata[PRESCALE_W-1:0];
        default: if (bus.writedata[0]) wrap_pending_d = 1'b0;
      endcase
    end
    // A wrap in the same cycle as a software clear keeps the flag set.
    if (wrap) wrap_pending_d = 1'b1;

    base_d = (mode_q == MODE_BLINK && !phase_q) ? '0 : work_q;
    irq_d  = wrap_pending_q & irq_en_q;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      mode_q         <= MODE_STATIC;
      en_q           <= 1'b0;
      irq_en_q       <= 1'b0;
      pattern_q      <= '0;
      period_q       <= '0;
      work_q         <= '0;
      presc_q        <= '0;
      step_cnt_q     <= '0;
      phase_q        <= 1'b1;
      wrap_pending_q <= 1'b0;
      base_q         <= '0;
      irq_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      en_q           <= en_d;
      irq_en_q       <= irq_en_d;
      pattern_q      <= pattern_d;
      period_q       <= period_d;
      work_q         <= work_d;
      presc_q        <= presc_d;
      step_cnt_q     <= step_cnt_d;
      phase_q        <= phase_d;
      wrap_pending_q <= wrap_pending_d;
      base_q         <= base_d;
      irq_q          <= irq_d;
    end
  end

`ifdef LED_SEQ_PWM_EN
  logic [7:0]       duty_q, duty_d, pwm_cnt_q, pwm_cnt_d;
  logic [WIDTH-1:0] out_port_q, out_port_d;

  always_comb begin
    duty_d = duty_q;
    if (wr_en && bus.address == 2'd0) duty_d = bus.writedata[15:8];
    pwm_cnt_d  = pwm_cnt_q + 8'd1;
    out_port_d = base_d & {WIDTH{pwm_cnt_q <= duty_q}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q     <= 8'hFF;
      pwm_cnt_q  <= '0;
      out_port_q <= '0;
    end else begin
      duty_q     <= duty_d;
      pwm_cnt_q  <= pwm_cnt_d;
      out_port_q <= out_port_d;
    end
  end

  assign duty_rd  = duty_q;
  assign out_port = out_port_q;
`else
  assign duty_rd  = 8'h00;
  assign out_port = base_q;
`endif

  assign status_word = {base_q, 7'b0, wrap_pending_q};
  assign irq         = irq_q;

  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      2'd0:    bus.readdata = {16'h0, duty_rd, 4'h0, irq_en_q, mode_q, en_q};
      2'd1:    bus.readdata = 32'(pattern_q);
      2'd2:    bus.readdata = 32'(period_q);
      default: bus.readdata = 32'(status_word);
    endcase
  end
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: expected out_port values are queued as
// stimulus is driven and compared one per cycle; register reads are checked inline.
module tb_led_pattern_sequencer;
  localparam int WIDTH      = 10;
  localparam int PRESCALE_W = 24;
`ifdef LED_SEQ_PWM_EN
  localparam logic [31:0] CTRL_RST = 32'h0000_FF00;
`else
  localparam logic [31:0] CTRL_RST = 32'h0000_0000;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] out_port;
  logic             irq;
  logic [WIDTH-1:0] exp_q[$];
  int               errors = 0;
  int               checks = 0;

  led_pattern_sequencer_if bus ();

  led_pattern_sequencer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int n);
    logic [WIDTH-1:0] r = v;
    for (int i = 0; i < n; i++) r = {r[WIDTH-2:0], r[WIDTH-1]};
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input int n);
    logic [WIDTH-1:0] r = v;
    for (int i = 0; i < n; i++) r = {r[0], r[WIDTH-1:1]};
    return r;
  endfunction

  // Advance one clock and compare out_port against the scoreboard head, if any.
  task automatic tick();
    logic [WIDTH-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (out_port !== e) begin
        errors++;
        $display("FAIL out_port @%0t: got %h expected %h", $time, out_port, e);
      end
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = data;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    data           = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    #12;
    checks++;
    if (out_port !== '0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got out_port=%h irq=%b expected 0/0", out_port, irq);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      checks++;
      if (rd !== ((a == 0) ? CTRL_RST : 32'h0)) begin
        errors++;
        $display("FAIL reset_readdata[%0d]: got %h expected %h", a, rd, (a == 0) ? CTRL_RST : 32'h0);
      end
    end
  endtask

  task automatic test_registers();
    logic [31:0] rd;
    bus_write(2'd0, 32'h0000_FFF8);
    bus_read(2'd0, rd);
    checks++;
    if (rd !== (CTRL_RST | 32'h8)) begin
      errors++;
      $display("FAIL ctrl_readback: got %h expected %h", rd, CTRL_RST | 32'h8);
    end
    exp_q.push_back('0);
    exp_q.push_back(10'h3FF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    tick();
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd1, rd);
    checks++;
    if (rd !== 32'h0000_03FF) begin
      errors++;
      $display("FAIL pattern_readback: got %h expected 000003ff", rd);
    end
    bus_read(2'd2, rd);
    checks++;
    if (rd !== 32'h00FF_FFFF) begin
      errors++;
      $display("FAIL period_readback: got %h expected 00ffffff", rd);
    end
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'h0003_FF00) begin
      errors++;
      $display("FAIL status_readback: got %h expected 0003ff00", rd);
    end
    bus_write(2'd0, CTRL_RST);
  endtask

  task automatic test_rotate_left();
    logic [31:0] rd;
    bus_write(2'd1, 32'h001);
    bus_write(2'd2, 32'd3);
    bus_write(2'd0, CTRL_RST | 32'h3);
    for (int k = 1; k <= 44; k++) exp_q.push_back(rotl(10'h001, ((k - 1) / 4) % WIDTH));
    for (int k = 1; k <= 44; k++) tick();
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'h0000_0101) begin
      errors++;
      $display("FAIL rol_wrap_status: got %h expected 00000101", rd);
    end
    bus_write(2'd0, CTRL_RST);
    bus_write(2'd3, 32'h1);
  endtask

  task automatic test_rotate_right_irq();
    logic [31:0] rd;
    bus_write(2'd1, 32'h201);
    bus_write(2'd2, 32'd0);
    bus_write(2'd3, 32'h1);
    bus_write(2'd0, CTRL_RST | 32'hD);
    for (int k = 1; k <= 12; k++) exp_q.push_back(rotr(10'h201, k - 1));
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 10 || k == 11) begin
        checks++;
        if (irq !== (k == 11)) begin
          errors++;
          $display("FAIL irq_after_wrap k=%0d: got %b expected %b", k, irq, k == 11);
        end
      end
    end
    exp_q.push_back(rotr(10'h201, 12));
    bus_write(2'd3, 32'h1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_on_clear_edge: got %b expected 1", irq);
    end
    exp_q.push_back(rotr(10'h201, 13));
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_cleared: got %b expected 0", irq);
    end
    bus_read(2'd3, rd);
    checks++;
    if (rd !== {14'h0, rotr(10'h201, 13), 8'h00}) begin
      errors++;
      $display("FAIL ror_status_cleared: got %h expected %h", rd, {14'h0, rotr(10'h201, 13), 8'h00});
    end
    for (int k = 15; k <= 19; k++) exp_q.push_back(rotr(10'h201, k - 1));
    for (int k = 15; k <= 19; k++) tick();
    // Clear lands on the edge of the second wrap: the set must win.
    exp_q.push_back(rotr(10'h201, 19));
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, rd);
    checks++;
    if (rd[0] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_vs_clear: got pending=%b expected 1", rd[0]);
    end
    exp_q.push_back(rotr(10'h201, 20));
    tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_second_wrap: got %b expected 1", irq);
    end
    bus_write(2'd0, CTRL_RST);
    bus_write(2'd3, 32'h1);
  endtask

  task automatic test_blink();
    logic [31:0] rd;
    bus_write(2'd1, 32'h155);
    bus_write(2'd2, 32'd1);
    bus_write(2'd3, 32'h1);
    bus_write(2'd0, CTRL_RST | 32'h7);
    for (int k = 1; k <= 8; k++) exp_q.push_back((((k - 1) / 2) % 2 == 1) ? 10'h000 : 10'h155);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 3 || k == 4) begin
        bus_read(2'd3, rd);
        checks++;
        if (rd[0] !== (k == 4)) begin
          errors++;
          $display("FAIL blink_wrap k=%0d: got pending=%b expected %b", k, rd[0], k == 4);
        end
      end
    end
    bus_write(2'd0, CTRL_RST);
    bus_write(2'd3, 32'h1);
  endtask

`ifdef LED_SEQ_PWM_EN
  task automatic test_pwm();
    logic [31:0] rd;
    int          on_cnt = 0;
    int          bad_cnt = 0;
    bus_write(2'd0, 32'h0000_3F00);
    bus_write(2'd1, 32'h3FF);
    tick();
    for (int k = 0; k < 256; k++) begin
      tick();
      if (out_port === 10'h3FF) on_cnt++;
      else if (out_port !== 10'h000) bad_cnt++;
    end
    checks++;
    if (on_cnt != 64 || bad_cnt != 0) begin
      errors++;
      $display("FAIL pwm_duty: got on=%0d other=%0d expected on=64 other=0", on_cnt, bad_cnt);
    end
    bus_read(2'd3, rd);
    checks++;
    if (rd !== 32'h0003_FF00) begin
      errors++;
      $display("FAIL pwm_status_ungated: got %h expected 0003ff00", rd);
    end
    bus_write(2'd0, CTRL_RST);
  endtask
`endif

  task automatic test_async_reset();
    logic [31:0] rd;
    bus_write(2'd1, 32'h001);
    bus_write(2'd2, 32'd0);
    bus_write(2'd0, CTRL_RST | 32'h3);
    for (int k = 1; k <= 3; k++) exp_q.push_back(rotl(10'h001, k - 1));
    for (int k = 1; k <= 3; k++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_port !== '0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got out_port=%h irq=%b expected 0/0", out_port, irq);
    end
    bus_read(2'd0, rd);
    checks++;
    if (rd !== CTRL_RST) begin
      errors++;
      $display("FAIL async_reset_ctrl: got %h expected %h", rd, CTRL_RST);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) exp_q.push_back('0);
    for (int k = 0; k < 6; k++) tick();
  endtask

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    test_reset();
    test_registers();
    test_rotate_left();
    test_rotate_right_irq();
    test_blink();
`ifdef LED_SEQ_PWM_EN
    test_pwm();
`endif
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
